// File: rtl/pwm_multicanal.sv
// N-channel PWM generator: shared period counter (edge- or center-aligned), per-channel
// duty compare with output polarity; PERIODO/DUTY/CENTER are shadowed at period boundaries.
module pwm_multicanal #(
  parameter int unsigned      N_CH    = 4,
  parameter int unsigned      W       = 15,
  parameter logic [W-1:0]     PER_DEF = W'(24_999)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                CENTER,
  input  logic [W-1:0]        PERIODO,
  input  logic [N_CH*W-1:0]   DUTY,
  input  logic [N_CH-1:0]     POL,
  output logic [N_CH-1:0]     PWM_OUT,
  output logic                TICK
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [W-1:0]             cnt, cnt_nxt;
  dir_t                     dir, dir_nxt, dir_cur;
  logic [W-1:0]             per_sh, per_eff;
  logic [N_CH-1:0][W-1:0]   duty_sh, duty_eff;
  logic                     mode_sh, mode_eff;
  logic                     boundary;
  logic [N_CH-1:0]          raw;

  // At a boundary the values being loaded already govern this edge, so the
  // whole new period (including its CNT=0 slot) uses the new settings.
  always_comb begin
    boundary = EN && (cnt == '0);
    per_eff  = boundary ? PERIODO : per_sh;
    mode_eff = boundary ? CENTER  : mode_sh;
    duty_eff = boundary ? DUTY    : duty_sh;
    dir_cur  = boundary ? DIR_UP  : dir;
    for (int unsigned i = 0; i < N_CH; i++)
      raw[i] = cnt < duty_eff[i];
  end

  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (EN && per_eff != '0) begin
      if (!mode_eff) begin
        cnt_nxt = (cnt == per_eff) ? '0 : cnt + 1'b1;
      end else if (dir_cur == DIR_UP) begin
        if (cnt == per_eff) begin
          cnt_nxt = cnt - 1'b1;
          dir_nxt = DIR_DOWN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        cnt_nxt = cnt - 1'b1;
        dir_nxt = (cnt == W'(1)) ? DIR_UP : DIR_DOWN;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      dir     <= DIR_UP;
      per_sh  <= PER_DEF;
      duty_sh <= '0;
      mode_sh <= 1'b0;
      PWM_OUT <= '0;
      TICK    <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
      TICK <= boundary;
      if (!EN || boundary) begin
        per_sh  <= PERIODO;
        duty_sh <= DUTY;
        mode_sh <= CENTER;
      end
      PWM_OUT <= EN ? (raw ^ POL) : POL;
    end
  end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Self-checking bench for pwm_multicanal: period-index reference model plus directed
// scenarios pinned by hand-counted literals, then randomized stimulus.
module tb_pwm_multicanal;
  localparam int W = 15;

  logic          CLK = 1'b0;
  logic          RST, EN, CENTER;
  logic [W-1:0]  PERIODO;
  logic [4*W-1:0] DUTY;
  logic [3:0]    POL;
  logic [3:0]    PWM_OUT;
  logic          TICK;

  pwm_multicanal #(.N_CH(4), .W(W), .PER_DEF(15'(24_999))) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CENTER(CENTER), .PERIODO(PERIODO),
    .DUTY(DUTY), .POL(POL), .PWM_OUT(PWM_OUT), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;
  // model: position within the current period and the period's loaded settings
  int p = 0, m_per = 0, m_center = 0;
  int m_duty[4];
  logic [3:0] exp_out = '0;
  logic       exp_tick = 1'b0;
  int hi[4];
  int ticks;

  function automatic int plen();
    if (m_per == 0) return 1;
    return m_center ? 2 * m_per : m_per + 1;
  endfunction

  function automatic int cnt_of(int pos);
    if (!m_center || pos <= m_per) return pos;
    return 2 * m_per - pos;
  endfunction

  task automatic model_edge();
    int c;
    if (RST) begin
      p = 0; exp_out = '0; exp_tick = 1'b0;
    end else if (!EN) begin
      p = 0; exp_out = POL; exp_tick = 1'b0;
    end else begin
      exp_tick = (p == 0);
      if (p == 0) begin
        m_per = int'(PERIODO);
        m_center = int'(CENTER);
        for (int i = 0; i < 4; i++) m_duty[i] = int'(DUTY[i*W +: W]);
      end
      c = cnt_of(p);
      for (int i = 0; i < 4; i++) exp_out[i] = (c < m_duty[i]) ^ POL[i];
      p = (p + 1) % plen();
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("pwm_out", int'(PWM_OUT), int'(exp_out));
    chk("tick", int'(TICK), int'(exp_tick));
    for (int i = 0; i < 4; i++) hi[i] += int'(PWM_OUT[i]);
    ticks += int'(TICK);
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    ticks = 0;
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
    DUTY = {15'(d3), 15'(d2), 15'(d1), 15'(d0)};
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CENTER = 1'b0; PERIODO = 15'd9; POL = 4'b0000;
    set_duty(3, 0, 10, 15);
    clr();
    #1;
    chk("reset_pwm", int'(PWM_OUT), 0);
    chk("reset_tick", int'(TICK), 0);
    cycle(); cycle();
    RST = 1'b0;
    cycle(); cycle();

    // edge mode, period 10
    EN = 1'b1; clr();
    repeat (20) cycle();
    chk("t1_ch0_high", hi[0], 6);
    chk("t1_ch1_high", hi[1], 0);
    chk("t1_ch2_high", hi[2], 20);
    chk("t1_ch3_high", hi[3], 20);
    chk("t1_ticks", ticks, 2);

    // duty change mid-period waits for the boundary
    clr();
    repeat (5) cycle();
    set_duty(7, 0, 10, 15);
    repeat (5) cycle();
    chk("t3_old_period", hi[0], 3);
    clr();
    repeat (10) cycle();
    chk("t3_new_period", hi[0], 7);
    chk("t3_ticks", ticks, 1);

    // polarity while disabled, then enable
    EN = 1'b0; POL = 4'b0001;
    cycle();
    chk("t4_idle_pol", int'(PWM_OUT), 1);
    EN = 1'b1;
    cycle();
    chk("t4_first_tick", int'(TICK), 1);
    chk("t4_pwm", int'(PWM_OUT), 4'b1100);
    repeat (4) cycle();

    // asynchronous reset mid-period
    RST = 1'b1;
    #1;
    chk("t5_async_pwm", int'(PWM_OUT), 0);
    chk("t5_async_tick", int'(TICK), 0);
    @(negedge CLK);
    cycle();
    RST = 1'b0;
    cycle();
    chk("t5_restart_tick", int'(TICK), 1);
    repeat (8) cycle();

    // center mode, period 2*5
    EN = 1'b0; POL = 4'b0000; CENTER = 1'b1; PERIODO = 15'd5;
    set_duty(2, 0, 6, 5);
    cycle();
    EN = 1'b1; clr();
    repeat (20) cycle();
    chk("t2_ticks", ticks, 2);
    chk("t2_ch2_high", hi[2], 20);

    // zero period: every cycle is a boundary
    CENTER = 1'b0; PERIODO = 15'd0; set_duty(1, 0, 0, 0);
    cycle(); clr();
    repeat (5) cycle();
    chk("t6_ticks", ticks, 5);
    chk("t6_ch0_high", hi[0], 5);
    set_duty(0, 0, 0, 0);
    cycle(); clr();
    repeat (5) cycle();
    chk("t6_ch0_zero", hi[0], 0);

    // randomized
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) PERIODO = 15'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0)
        set_duty($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 20) == 0) CENTER = ~CENTER;
      if ($urandom_range(0, 30) == 0) POL = 4'($urandom_range(0, 15));
      EN = ($urandom_range(0, 40) != 0);
      if ($urandom_range(0, 200) == 0) begin
        RST = 1'b1;
        #1;
        chk("rand_async_pwm", int'(PWM_OUT), 0);
        @(negedge CLK);
        cycle();
        RST = 1'b0;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
